// File: rtl/bitstream_decoder_if.sv
// Handshake and data bundle between the bitstream fabric, the decoder and the readout consumer.
// COUNT_W is derived from WINDOW so both ends always agree on the count width.
interface bitstream_decoder_if #(
    parameter int CHANNELS = 2,
    parameter int WINDOW   = 256
);
    localparam int COUNT_W = $clog2(WINDOW + 1);

    logic                        start;
    logic [CHANNELS-1:0]         stream_in;
    logic                        in_valid;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [CHANNELS*COUNT_W-1:0] out_counts;

    modport master (
        output start, stream_in, in_valid, out_ready,
        input  busy, out_valid, out_counts
    );

    modport slave (
        input  start, stream_in, in_valid, out_ready,
        output busy, out_valid, out_counts
    );
endinterface

// File: rtl/bitstream_decoder.sv
// Counts ones per channel over WINDOW qualified samples and holds the counts
// on a valid/ready output until the consumer accepts them.
module bitstream_decoder #(
    parameter  int CHANNELS = 2,
    parameter  int WINDOW   = 256,
    localparam int COUNT_W  = $clog2(WINDOW + 1)
) (
    input  logic                clk,
    input  logic                rst,
    bitstream_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] LAST_SAMPLE = COUNT_W'(WINDOW - 1);

    state_t                      state;
    logic [CHANNELS*COUNT_W-1:0] cnt;
    logic [CHANNELS*COUNT_W-1:0] cnt_next;
    logic [COUNT_W-1:0]          samples;
    logic                        busy;
    logic                        out_valid;
    logic [CHANNELS*COUNT_W-1:0] out_counts;

    // Per-channel counts after adding the current sample bits
    always_comb begin
        cnt_next = cnt;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next[i*COUNT_W +: COUNT_W] = cnt[i*COUNT_W +: COUNT_W] + COUNT_W'(bus.stream_in[i]);
        end
    end

    // Conversion FSM with registered status and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            samples    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_counts <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= COUNT;
                        cnt     <= '0;
                        samples <= '0;
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (bus.in_valid) begin
                        cnt     <= cnt_next;
                        samples <= samples + COUNT_W'(1);
                        // The final sample goes straight into the result register
                        if (samples == LAST_SAMPLE) begin
                            out_counts <= cnt_next;
                            out_valid  <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (bus.start) begin
                            state   <= COUNT;
                            cnt     <= '0;
                            samples <= '0;
                            busy    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.out_valid  = out_valid;
    assign bus.out_counts = out_counts;
endmodule
